// File: rtl/quant_zigzag_pkg.sv
// Shared constants, FSM states and the per-position quantizer shift for quant_zigzag.
package quant_zigzag_pkg;

  localparam int QZ_COEFF_W = 16;
  localparam int QZ_OUT_W   = 8;
  localparam int QZ_QBASE   = 2;
  localparam int QZ_SHIFT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2
  } qz_state_t;

  // JPEG zigzag scan: entry i is the raster index 8*u+v sent at position i.
  localparam logic [5:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic logic [QZ_SHIFT_W-1:0] shift_for(input logic [5:0] k,
                                                      input int qbase = QZ_QBASE);
    int u;
    int v;
    u = int'(k[5:3]);
    v = int'(k[2:0]);
    return QZ_SHIFT_W'(qbase + ((u + v) >> 2));
  endfunction

endpackage

// File: rtl/quant_zigzag_quantize.sv
// Combinational round-half-up arithmetic right shift followed by saturation to OUT_W bits.
module qz_quantize #(
  parameter int COEFF_W = 16,
  parameter int OUT_W   = 8,
  parameter int SW      = 4
) (
  input  logic [COEFF_W-1:0] c,
  input  logic [SW-1:0]      s,
  output logic [OUT_W-1:0]   q
);

  localparam int W = COEFF_W + 1;
  localparam logic signed [W-1:0] MAXV = W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [W-1:0] MINV = ~MAXV;

  logic signed [W-1:0] c_ext;
  logic signed [W-1:0] rnd;
  logic signed [W-1:0] sum;
  logic signed [W-1:0] shifted;

  always_comb begin
    c_ext   = {c[COEFF_W-1], c};
    rnd     = (s == '0) ? '0 : (W'(1) << (s - SW'(1)));
    // one extra bit keeps the rounding add from wrapping at the top of the range
    sum     = c_ext + rnd;
    shifted = sum >>> s;
    if (shifted > MAXV) begin
      q = MAXV[OUT_W-1:0];
    end else if (shifted < MINV) begin
      q = MINV[OUT_W-1:0];
    end else begin
      q = shifted[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/quant_zigzag.sv
// Captures a 64-coefficient DCT block, quantizes it and streams it out in zigzag order.
//   state  | meaning
//   IDLE   | waiting for dct_valid, in_ready = 1
//   FILL   | block captured, loading zigzag position 0 into the output register
//   STREAM | output register valid, advancing one position per handshake
module quant_zigzag
  import quant_zigzag_pkg::*;
#(
  parameter int COEFF_W = QZ_COEFF_W,
  parameter int OUT_W   = QZ_OUT_W,
  parameter int QBASE   = QZ_QBASE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [64*COEFF_W-1:0]  dct_in,
  input  logic                   dct_valid,
  output logic                   in_ready,
  output logic [OUT_W-1:0]       coeff_out,
  output logic [5:0]             coeff_pos,
  output logic                   coeff_last,
  output logic                   coeff_valid,
  input  logic                   coeff_ready,
  output logic                   overflow
);

  qz_state_t state_q, state_d;
  logic [5:0]         idx_q, idx_d;
  logic [COEFF_W-1:0] buf_q [64];
  logic [COEFF_W-1:0] buf_d [64];
  logic [OUT_W-1:0]   out_q, out_d;
  logic [5:0]         pos_q, pos_d;
  logic               last_q, last_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;

  logic               capture;
  logic               load;
  logic [5:0]         sel_k;
  logic [QZ_SHIFT_W-1:0] sel_s;
  logic [OUT_W-1:0]   q_w;

  assign sel_k = ZIGZAG[idx_q];
  assign sel_s = shift_for(sel_k, QBASE);

  qz_quantize #(
    .COEFF_W (COEFF_W),
    .OUT_W   (OUT_W),
    .SW      (QZ_SHIFT_W)
  ) u_quant (
    .c (buf_q[sel_k]),
    .s (sel_s),
    .q (q_w)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    out_d   = out_q;
    pos_d   = pos_q;
    last_d  = last_q;
    valid_d = valid_q;
    ovf_d   = ovf_q | (dct_valid && (state_q != IDLE));
    capture = 1'b0;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (dct_valid) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        load    = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (valid_q && coeff_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            state_d = IDLE;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      out_d   = q_w;
      pos_d   = idx_q;
      last_d  = (idx_q == 6'd63);
      valid_d = 1'b1;
      idx_d   = idx_q + 6'd1;
    end
  end

  always_comb begin
    buf_d = buf_q;
    if (capture) begin
      for (int k = 0; k < 64; k++) begin
        buf_d[k] = dct_in[k*COEFF_W +: COEFF_W];
      end
    end
  end

  // The block buffer carries no reset; its contents are only read after a capture.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      out_q   <= '0;
      pos_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      pos_q   <= pos_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign coeff_out   = out_q;
  assign coeff_pos   = pos_q;
  assign coeff_last  = last_q;
  assign coeff_valid = valid_q;
  assign overflow    = ovf_q;

endmodule
